dispatch_multi: RTL and testbench

- Parametrised, DISPATCH_WIDTH-wide in-order dispatch stage between the fetch/instruction queue and the ROB plus reservation stations.
- Stages a group of up to DISPATCH_WIDTH instructions and dispatches as many as ROB and RS free space allows, oldest first.
- Keeps any undispatched remainder for later cycles and resolves register dependencies between instructions of the same group.

---
 rtl/dispatch_multi.sv | 212 +++++++++++++++++++++
 tb/tb_dispatch_multi.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dispatch_multi: DISPATCH_WIDTH-wide in-order dispatch with group rename.  |
// | ROB op encoding: 2'd0 INT, 2'd1 BR, 2'd2 LD, 2'd3 ST.   Rev 1.0           |
// +--------------------------------------------------------------------------+
module dispatch_multi #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TAG_WIDTH      = 6,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = $clog2(DISPATCH_WIDTH + 1)
) (
  input  logic                                       clk,
  input  logic                                       n_rst,
  input  logic                                       i_flush,
  input  logic [DISPATCH_WIDTH-1:0]                  i_fetch_valid,
  input  logic [DISPATCH_WIDTH*DATA_WIDTH-1:0]       i_fetch_insn,
  input  logic [DISPATCH_WIDTH*ADDR_WIDTH-1:0]       i_fetch_iaddr,
  output logic                                       o_fetch_ready,
  input  logic [CNT_WIDTH-1:0]                       i_rob_free_cnt,
  input  logic [CNT_WIDTH-1:0]                       i_rs_free_cnt,
  input  logic [TAG_WIDTH-1:0]                       i_rob_tag,
  input  logic [2*DISPATCH_WIDTH-1:0]                i_rob_src_rdy,
  input  logic [2*DISPATCH_WIDTH*TAG_WIDTH-1:0]      i_rob_src_tag,
  input  logic [2*DISPATCH_WIDTH*DATA_WIDTH-1:0]     i_rob_src_data,
  output logic [2*DISPATCH_WIDTH*REG_ADDR_WIDTH-1:0] o_rsrc,
  output logic [DISPATCH_WIDTH-1:0]                  o_disp_en,
  output logic [DISPATCH_WIDTH*7-1:0]                o_opcode,
  output logic [DISPATCH_WIDTH*DATA_WIDTH-1:0]       o_insn,
  output logic [DISPATCH_WIDTH*ADDR_WIDTH-1:0]       o_iaddr,
  output logic [DISPATCH_WIDTH*2-1:0]                o_rob_op,
  output logic [DISPATCH_WIDTH*REG_ADDR_WIDTH-1:0]   o_rdest,
  output logic [DISPATCH_WIDTH*TAG_WIDTH-1:0]        o_dst_tag,
  output logic [2*DISPATCH_WIDTH-1:0]                o_src_rdy,
  output logic [2*DISPATCH_WIDTH*TAG_WIDTH-1:0]      o_src_tag,
  output logic [2*DISPATCH_WIDTH*DATA_WIDTH-1:0]     o_src_data
);

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [1:0] ROB_OP_INT = 2'd0;
  localparam logic [1:0] ROB_OP_BR  = 2'd1;
  localparam logic [1:0] ROB_OP_LD  = 2'd2;
  localparam logic [1:0] ROB_OP_ST  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(DISPATCH_WIDTH);

  logic [DISPATCH_WIDTH-1:0]   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]       insn_q  [DISPATCH_WIDTH];
  logic [DATA_WIDTH-1:0]       insn_d  [DISPATCH_WIDTH];
  logic [ADDR_WIDTH-1:0]       iaddr_q [DISPATCH_WIDTH];
  logic [ADDR_WIDTH-1:0]       iaddr_d [DISPATCH_WIDTH];

  logic [CNT_WIDTH-1:0]        staged_cnt, rob_cnt, rs_cnt, disp_cnt;
  logic [TAG_WIDTH-1:0]        dst_tag [DISPATCH_WIDTH];
  logic [6:0]                  opc     [DISPATCH_WIDTH];
  logic [REG_ADDR_WIDTH-1:0]   rdest   [DISPATCH_WIDTH];
  logic [1:0]                  rob_op  [DISPATCH_WIDTH];
  logic [REG_ADDR_WIDTH-1:0]   rsrc    [2*DISPATCH_WIDTH];
  logic [2*DISPATCH_WIDTH-1:0] src_used;
  logic [DISPATCH_WIDTH-1:0]   fetch_valid_inc;

  always_comb begin
    staged_cnt = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      staged_cnt = staged_cnt + CNT_WIDTH'(valid_q[k]);
    end
    rob_cnt  = (i_rob_free_cnt > MAX_CNT) ? MAX_CNT : i_rob_free_cnt;
    rs_cnt   = (i_rs_free_cnt > MAX_CNT) ? MAX_CNT : i_rs_free_cnt;
    disp_cnt = staged_cnt;
    if (rob_cnt < disp_cnt) disp_cnt = rob_cnt;
    if (rs_cnt < disp_cnt)  disp_cnt = rs_cnt;
  end

  assign o_fetch_ready = (disp_cnt == staged_cnt) && !i_flush;

  for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_lane
    assign o_disp_en[k]  = (CNT_WIDTH'(k) < disp_cnt) && !i_flush;
    assign dst_tag[k]    = i_rob_tag + TAG_WIDTH'(k);
    assign rsrc[2*k]     = REG_ADDR_WIDTH'(insn_q[k][19:15]);
    assign rsrc[2*k+1]   = REG_ADDR_WIDTH'(insn_q[k][24:20]);
    assign o_dst_tag[k*TAG_WIDTH +: TAG_WIDTH]           = dst_tag[k];
    assign o_insn[k*DATA_WIDTH +: DATA_WIDTH]            = insn_q[k];
    assign o_iaddr[k*ADDR_WIDTH +: ADDR_WIDTH]           = iaddr_q[k];
    assign o_opcode[k*7 +: 7]                            = opc[k];
    assign o_rob_op[k*2 +: 2]                            = rob_op[k];
    assign o_rdest[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]   = rdest[k];
    assign o_rsrc[2*k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]      = rsrc[2*k];
    assign o_rsrc[(2*k+1)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]  = rsrc[2*k+1];
  end

  always_comb begin
    src_used = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      opc[k]    = insn_q[k][6:0];
      rdest[k]  = REG_ADDR_WIDTH'(insn_q[k][11:7]);
      rob_op[k] = ROB_OP_INT;
      case (insn_q[k][6:0])
        OPC_OPIMM: src_used[2*k] = 1'b1;
        OPC_LOAD: begin
          src_used[2*k] = 1'b1;
          rob_op[k]     = ROB_OP_LD;
        end
        OPC_JALR: begin
          src_used[2*k] = 1'b1;
          rob_op[k]     = ROB_OP_BR;
        end
        OPC_LUI, OPC_AUIPC: begin
        end
        OPC_JAL: rob_op[k] = ROB_OP_BR;
        OPC_OP: begin
          src_used[2*k]   = 1'b1;
          src_used[2*k+1] = 1'b1;
        end
        OPC_BRANCH: begin
          src_used[2*k]   = 1'b1;
          src_used[2*k+1] = 1'b1;
          rob_op[k]       = ROB_OP_BR;
          rdest[k]        = '0;
        end
        OPC_STORE: begin
          src_used[2*k]   = 1'b1;
          src_used[2*k+1] = 1'b1;
          rob_op[k]       = ROB_OP_ST;
          rdest[k]        = '0;
        end
        default: begin
          opc[k]   = OPC_OPIMM;
          rdest[k] = '0;
        end
      endcase
    end
  end

  // Ascending scan so the youngest older producer in the group wins.
  always_comb begin
    o_src_rdy  = '1;
    o_src_tag  = '0;
    o_src_data = '0;
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      for (int s = 0; s < 2; s++) begin
        if (src_used[2*j+s] && (rsrc[2*j+s] != '0)) begin
          o_src_rdy[2*j+s] = i_rob_src_rdy[2*j+s];
          o_src_tag[(2*j+s)*TAG_WIDTH +: TAG_WIDTH] =
            i_rob_src_tag[(2*j+s)*TAG_WIDTH +: TAG_WIDTH];
          o_src_data[(2*j+s)*DATA_WIDTH +: DATA_WIDTH] =
            i_rob_src_data[(2*j+s)*DATA_WIDTH +: DATA_WIDTH];
          for (int i = 0; i < j; i++) begin
            if ((rdest[i] != '0) && (rdest[i] == rsrc[2*j+s])) begin
              o_src_rdy[2*j+s] = 1'b0;
              o_src_tag[(2*j+s)*TAG_WIDTH +: TAG_WIDTH]    = dst_tag[i];
              o_src_data[(2*j+s)*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    valid_d = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      insn_d[k]  = insn_q[k];
      iaddr_d[k] = iaddr_q[k];
    end
    if (o_fetch_ready) begin
      valid_d = i_fetch_valid;
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        insn_d[k]  = i_fetch_insn[k*DATA_WIDTH +: DATA_WIDTH];
        iaddr_d[k] = i_fetch_iaddr[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end else if (!i_flush) begin
      for (int m = 0; m <= DISPATCH_WIDTH; m++) begin
        if (CNT_WIDTH'(m) == disp_cnt) begin
          for (int k = 0; k + m < DISPATCH_WIDTH; k++) begin
            valid_d[k] = valid_q[k+m];
            insn_d[k]  = insn_q[k+m];
            iaddr_d[k] = iaddr_q[k+m];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      insn_q[k]  <= insn_d[k];
      iaddr_q[k] <= iaddr_d[k];
    end
  end

  assign fetch_valid_inc = i_fetch_valid + DISPATCH_WIDTH'(1);

  a_fetch_valid_contig: assert property (@(posedge clk) disable iff (!n_rst)
    (i_fetch_valid & fetch_valid_inc) == '0);

endmodule
`default_nettype wire

// File: tb/tb_dispatch_multi.sv
`default_nettype none
// tb_dispatch_multi: directed vector table plus multi-cycle sequences, W=2.
module tb_dispatch_multi;
  localparam logic [1:0] INT = 2'd0, BR = 2'd1, LD = 2'd2, ST = 2'd3;

  logic          clk, n_rst, flush;
  logic [1:0]    fetch_valid;
  logic [63:0]   fetch_insn, fetch_iaddr;
  logic          fetch_ready;
  logic [1:0]    rob_free, rs_free;
  logic [5:0]    rob_tag;
  logic [3:0]    lk_rdy;
  logic [23:0]   lk_tag;
  logic [127:0]  lk_data;
  logic [19:0]   rsrc;
  logic [1:0]    disp_en;
  logic [13:0]   opcode;
  logic [63:0]   o_insn, o_iaddr;
  logic [3:0]    rob_op;
  logic [9:0]    rdest;
  logic [11:0]   dst_tag;
  logic [3:0]    src_rdy;
  logic [23:0]   src_tag;
  logic [127:0]  src_data;

  dispatch_multi #(
    .DISPATCH_WIDTH(2), .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .TAG_WIDTH(6), .REG_ADDR_WIDTH(5), .CNT_WIDTH(2)
  ) dut (
    .clk(clk), .n_rst(n_rst), .i_flush(flush),
    .i_fetch_valid(fetch_valid), .i_fetch_insn(fetch_insn), .i_fetch_iaddr(fetch_iaddr),
    .o_fetch_ready(fetch_ready),
    .i_rob_free_cnt(rob_free), .i_rs_free_cnt(rs_free), .i_rob_tag(rob_tag),
    .i_rob_src_rdy(lk_rdy), .i_rob_src_tag(lk_tag), .i_rob_src_data(lk_data),
    .o_rsrc(rsrc), .o_disp_en(disp_en), .o_opcode(opcode),
    .o_insn(o_insn), .o_iaddr(o_iaddr), .o_rob_op(rob_op), .o_rdest(rdest),
    .o_dst_tag(dst_tag), .o_src_rdy(src_rdy), .o_src_tag(src_tag), .o_src_data(src_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string            nm;
    logic [1:0]       valid;
    logic [31:0]      i0, i1;
    logic [1:0]       robf, rsf;
    logic [5:0]       tag;
    logic [3:0]       lkrdy;
    logic [1:0]       e_en;
    logic             e_ready;
    logic [1:0][6:0]  e_opc;
    logic [1:0][1:0]  e_rop;
    logic [1:0][4:0]  e_rd;
    logic [1:0][5:0]  e_dtag;
    logic [3:0]       e_srdy;
    logic [3:0][5:0]  e_stag;
    logic [3:0]       e_dlk;   // 1: data comes from the lookup, 0: data must be zero
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] mk(logic [6:0] opc, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, opc};
  endfunction

  function automatic vec_t mkvec(string nm, logic [1:0] valid, logic [31:0] i0, logic [31:0] i1,
                                 logic [1:0] robf, logic [1:0] rsf, logic [5:0] tag, logic [3:0] lkrdy,
                                 logic [1:0] e_en, logic e_ready, logic [13:0] e_opc, logic [3:0] e_rop,
                                 logic [9:0] e_rd, logic [11:0] e_dtag, logic [3:0] e_srdy,
                                 logic [23:0] e_stag, logic [3:0] e_dlk);
    vec_t v;
    v.nm = nm; v.valid = valid; v.i0 = i0; v.i1 = i1; v.robf = robf; v.rsf = rsf;
    v.tag = tag; v.lkrdy = lkrdy; v.e_en = e_en; v.e_ready = e_ready; v.e_opc = e_opc;
    v.e_rop = e_rop; v.e_rd = e_rd; v.e_dtag = e_dtag; v.e_srdy = e_srdy;
    v.e_stag = e_stag; v.e_dlk = e_dlk;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Flush out any leftovers, then stage a fresh group with no free space.
  task automatic load_group(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    flush = 1'b1; fetch_valid = 2'b00; rob_free = 2'd0; rs_free = 2'd0;
    @(negedge clk);
    flush = 1'b0; fetch_valid = v; fetch_insn = {b, a}; fetch_iaddr = {32'h104, 32'h100};
    #1 chk("load ready", 32'(fetch_ready), 32'd1);
    @(negedge clk);
    fetch_valid = 2'b00;
  endtask

  task automatic check_out(input vec_t v);
    chk({v.nm, " en"}, 32'(disp_en), 32'(v.e_en));
    chk({v.nm, " ready"}, 32'(fetch_ready), 32'(v.e_ready));
    for (int k = 0; k < 2; k++) begin
      if (v.e_en[k]) begin
        chk($sformatf("%s opcode%0d", v.nm, k), 32'(opcode[k*7 +: 7]), 32'(v.e_opc[k]));
        chk($sformatf("%s rob_op%0d", v.nm, k), 32'(rob_op[k*2 +: 2]), 32'(v.e_rop[k]));
        chk($sformatf("%s rdest%0d", v.nm, k), 32'(rdest[k*5 +: 5]), 32'(v.e_rd[k]));
        chk($sformatf("%s dst_tag%0d", v.nm, k), 32'(dst_tag[k*6 +: 6]), 32'(v.e_dtag[k]));
        for (int s = 0; s < 2; s++) begin
          int idx;
          idx = 2*k + s;
          chk($sformatf("%s src_rdy%0d", v.nm, idx), 32'(src_rdy[idx]), 32'(v.e_srdy[idx]));
          if (v.e_srdy[idx])
            chk($sformatf("%s src_data%0d", v.nm, idx), src_data[idx*32 +: 32],
                v.e_dlk[idx] ? (32'hA000_0001 + 32'(idx)) : 32'd0);
          else
            chk($sformatf("%s src_tag%0d", v.nm, idx), 32'(src_tag[idx*6 +: 6]), 32'(v.e_stag[idx]));
        end
      end
    end
  endtask

  initial begin
    n_rst = 1'b0; flush = 1'b0; fetch_valid = 2'b00; fetch_insn = '0; fetch_iaddr = '0;
    rob_free = 2'd2; rs_free = 2'd2; rob_tag = 6'd0; lk_rdy = 4'hF;
    lk_tag  = {6'd14, 6'd13, 6'd12, 6'd11};
    lk_data = {32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 32'hA000_0001};

    vecs.push_back(mkvec("dep", 2'b11, mk(7'h13, 5'd1, 5'd0, 5'd1), mk(7'h33, 5'd2, 5'd1, 5'd1),
      2'd2, 2'd2, 6'd5, 4'hF, 2'b11, 1'b1, {7'h33, 7'h13}, {INT, INT}, {5'd2, 5'd1},
      {6'd6, 6'd5}, 4'b0011, {6'd5, 6'd5, 6'd0, 6'd0}, 4'b0000));
    vecs.push_back(mkvec("wrap", 2'b11, mk(7'h13, 5'd3, 5'd4, 5'd7), mk(7'h03, 5'd5, 5'd6, 5'd0),
      2'd2, 2'd2, 6'd63, 4'hF, 2'b11, 1'b1, {7'h03, 7'h13}, {LD, INT}, {5'd5, 5'd3},
      {6'd0, 6'd63}, 4'b1111, 24'd0, 4'b0101));
    vecs.push_back(mkvec("st_br", 2'b11, mk(7'h23, 5'd9, 5'd8, 5'd7), mk(7'h63, 5'd4, 5'd0, 5'd9),
      2'd2, 2'd2, 6'd10, 4'hF, 2'b11, 1'b1, {7'h63, 7'h23}, {BR, ST}, {5'd0, 5'd0},
      {6'd11, 6'd10}, 4'b1111, 24'd0, 4'b1011));
    vecs.push_back(mkvec("unknown", 2'b11, mk(7'h7F, 5'd3, 5'd1, 5'd2), mk(7'h33, 5'd4, 5'd3, 5'd3),
      2'd2, 2'd2, 6'd30, 4'h0, 2'b11, 1'b1, {7'h33, 7'h13}, {INT, INT}, {5'd4, 5'd0},
      {6'd31, 6'd30}, 4'b0011, {6'd14, 6'd13, 6'd0, 6'd0}, 4'b0000));
    vecs.push_back(mkvec("jal_jalr", 2'b11, mk(7'h6F, 5'd1, 5'd2, 5'd3), mk(7'h67, 5'd2, 5'd1, 5'd5),
      2'd3, 2'd2, 6'd20, 4'hF, 2'b11, 1'b1, {7'h67, 7'h6F}, {BR, BR}, {5'd2, 5'd1},
      {6'd21, 6'd20}, 4'b1011, {6'd0, 6'd20, 6'd0, 6'd0}, 4'b0000));
    vecs.push_back(mkvec("lui_rs1", 2'b11, mk(7'h37, 5'd5, 5'd5, 5'd5), mk(7'h17, 5'd6, 5'd5, 5'd5),
      2'd2, 2'd1, 6'd40, 4'hF, 2'b01, 1'b0, {7'h17, 7'h37}, {INT, INT}, {5'd6, 5'd5},
      {6'd41, 6'd40}, 4'b1111, 24'd0, 4'b0000));
    vecs.push_back(mkvec("single", 2'b01, mk(7'h33, 5'd7, 5'd7, 5'd7), mk(7'h33, 5'd8, 5'd7, 5'd7),
      2'd2, 2'd2, 6'd50, 4'hF, 2'b01, 1'b1, {7'h33, 7'h33}, {INT, INT}, {5'd8, 5'd7},
      {6'd51, 6'd50}, 4'b1111, 24'd0, 4'b0011));

    #12;
    chk("reset en", 32'(disp_en), 32'd0);
    chk("reset ready", 32'(fetch_ready), 32'd1);
    @(negedge clk);
    n_rst = 1'b1;

    foreach (vecs[n]) begin
      load_group(vecs[n].valid, vecs[n].i0, vecs[n].i1);
      rob_free = vecs[n].robf; rs_free = vecs[n].rsf; rob_tag = vecs[n].tag; lk_rdy = vecs[n].lkrdy;
      #1 check_out(vecs[n]);
    end

    // Partial dispatch leaves the ADD in slot 0 for the next cycle.
    load_group(2'b11, mk(7'h13, 5'd1, 5'd0, 5'd1), mk(7'h33, 5'd2, 5'd1, 5'd1));
    rob_free = 2'd1; rs_free = 2'd2; rob_tag = 6'd5; lk_rdy = 4'hF;
    #1;
    chk("part en", 32'(disp_en), 32'd1);
    chk("part ready", 32'(fetch_ready), 32'd0);
    chk("part tag0", 32'(dst_tag[5:0]), 32'd5);
    @(negedge clk);
    rob_free = 2'd2; rob_tag = 6'd6;
    #1;
    chk("rem en", 32'(disp_en), 32'd1);
    chk("rem ready", 32'(fetch_ready), 32'd1);
    chk("rem opcode", 32'(opcode[6:0]), 32'h33);
    chk("rem insn", o_insn[31:0], mk(7'h33, 5'd2, 5'd1, 5'd1));
    chk("rem dst_tag", 32'(dst_tag[5:0]), 32'd6);
    chk("rem rsrc", 32'(rsrc[9:0]), 32'({5'd1, 5'd1}));
    chk("rem src_rdy", 32'(src_rdy[1:0]), 32'd3);
    chk("rem data0", src_data[31:0], 32'hA000_0001);
    chk("rem data1", src_data[63:32], 32'hA000_0002);

    // Stall with no RS space, then flush.
    load_group(2'b11, mk(7'h13, 5'd3, 5'd0, 5'd1), mk(7'h13, 5'd4, 5'd0, 5'd2));
    rob_free = 2'd2; rs_free = 2'd0;
    #1;
    chk("stall en", 32'(disp_en), 32'd0);
    chk("stall ready", 32'(fetch_ready), 32'd0);
    @(negedge clk);
    flush = 1'b1; rs_free = 2'd2;
    #1;
    chk("flush en", 32'(disp_en), 32'd0);
    chk("flush ready", 32'(fetch_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("postflush en", 32'(disp_en), 32'd0);
    chk("postflush ready", 32'(fetch_ready), 32'd1);

    // Asynchronous reset between clock edges.
    load_group(2'b11, mk(7'h13, 5'd3, 5'd0, 5'd1), mk(7'h13, 5'd4, 5'd0, 5'd2));
    rob_free = 2'd2; rs_free = 2'd2;
    #1 chk("prerst en", 32'(disp_en), 32'd3);
    #2 n_rst = 1'b0;
    #1;
    chk("async rst en", 32'(disp_en), 32'd0);
    chk("async rst ready", 32'(fetch_ready), 32'd1);
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    chk("after rst en", 32'(disp_en), 32'd0);
    chk("after rst ready", 32'(fetch_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
